// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles RV32I words from four byte reads of a
// single-port memory and hands them to IF/ID through a one-entry buffer.
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              branch_in,
  input  logic [ADDR_W-1:0] branchAddr_in,
  input  logic [7:0]        memData_in,
  output logic [ADDR_W-1:0] memAddr_out,
  output logic              memRE_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       inst_out,
  output logic              instValid_out
);

  typedef enum logic [2:0] {
    ST_F0,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_W3,
    ST_PEND
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       stage_q;
  logic              consume;
  logic              buf_free;
  logic              refill;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;

  // The buffer can take a new word if it is empty or being drained this cycle.
  assign consume  = instValid_out & ~stall_in;
  assign buf_free = ~instValid_out | ~stall_in;
  assign refill   = ((state_q == ST_W3) || (state_q == ST_PEND)) && buf_free;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_F0;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (branch_in) begin
      state_d = ST_F0;
    end else begin
      unique case (state_q)
        ST_F0:   state_d = ST_F1;
        ST_F1:   state_d = ST_F2;
        ST_F2:   state_d = ST_F3;
        ST_F3:   state_d = ST_W3;
        ST_W3:   state_d = buf_free ? ST_F0 : ST_PEND;
        ST_PEND: state_d = buf_free ? ST_F0 : ST_PEND;
        default: state_d = ST_F0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr = pc_q;
    mem_re   = 1'b0;
    unique case (state_q)
      ST_F0: begin
        mem_addr = pc_q;
        mem_re   = 1'b1;
      end
      ST_F1: begin
        mem_addr = pc_q + ADDR_W'(1);
        mem_re   = 1'b1;
      end
      ST_F2: begin
        mem_addr = pc_q + ADDR_W'(2);
        mem_re   = 1'b1;
      end
      ST_F3: begin
        mem_addr = pc_q + ADDR_W'(3);
        mem_re   = 1'b1;
      end
      default: begin
        mem_addr = pc_q;
        mem_re   = 1'b0;
      end
    endcase
  end

  assign memAddr_out = mem_addr;
  assign memRE_out   = mem_re & ~rst_in;

  // ---------------------------------------------------------------------------
  // PC, staging register and output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q          <= RESET_PC;
      stage_q       <= '0;
      pc_out        <= '0;
      inst_out      <= '0;
      instValid_out <= 1'b0;
    end else if (branch_in) begin
      // A redirect discards everything in flight, including a stalled word.
      pc_q          <= branchAddr_in;
      stage_q       <= '0;
      pc_out        <= '0;
      inst_out      <= '0;
      instValid_out <= 1'b0;
    end else begin
      // Drained without a refill this edge; a refill below overrides it.
      if (consume) begin
        instValid_out <= 1'b0;
      end

      unique case (state_q)
        ST_F1: stage_q[7:0]   <= memData_in;
        ST_F2: stage_q[15:8]  <= memData_in;
        ST_F3: stage_q[23:16] <= memData_in;
        ST_W3: begin
          if (!buf_free) begin
            stage_q[31:24] <= memData_in;
          end
        end
        default: ;
      endcase

      if (refill) begin
        inst_out      <= (state_q == ST_W3) ? {memData_in, stage_q[23:0]} : stage_q;
        pc_out        <= pc_q;
        instValid_out <= 1'b1;
        pc_q          <= pc_q + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a 1-cycle-latency byte memory model drives two
// DUT instances (default reset PC and a reset PC at the top of the address space).
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_in = 1'b0;
  logic [31:0] branchAddr_in = '0;
  logic [7:0]  memData_in = '0;
  logic [31:0] memAddr_out;
  logic        memRE_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        instValid_out;

  logic [7:0]  mem_data2 = '0;
  logic [31:0] mem_addr2;
  logic        mem_re2;
  logic [31:0] pc2;
  logic [31:0] inst2;
  logic        valid2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  if_fetch dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .stall_in      (stall_in),
    .branch_in     (branch_in),
    .branchAddr_in (branchAddr_in),
    .memData_in    (memData_in),
    .memAddr_out   (memAddr_out),
    .memRE_out     (memRE_out),
    .pc_out        (pc_out),
    .inst_out      (inst_out),
    .instValid_out (instValid_out)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .stall_in      (1'b0),
    .branch_in     (1'b0),
    .branchAddr_in (32'h0),
    .memData_in    (mem_data2),
    .memAddr_out   (mem_addr2),
    .memRE_out     (mem_re2),
    .pc_out        (pc2),
    .inst_out      (inst2),
    .instValid_out (valid2)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0513;
      32'h0000_0004: return 32'h0020_0593;
      32'h0000_0008: return 32'h0030_0613;
      32'h0000_000C: return 32'h0040_0693;
      32'h0000_0100: return 32'h0640_0713;
      32'hFFFF_FFFC: return 32'h1234_5678;
      default:       return 32'hA5A5_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  always @(posedge clk_in) begin
    if (memRE_out) memData_in <= byte_at(memAddr_out);
    if (mem_re2)   mem_data2  <= byte_at(mem_addr2);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    stall_in  = 1'b0;
    branch_in = 1'b0;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    n_cmp++; if (memRE_out !== 1'b0) begin n_fail++; $display("FAIL reset_re got=%b want=0", memRE_out); end
    n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", instValid_out); end
    n_cmp++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h want=0", inst_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0", pc_out); end
    rst_in = 1'b0;
    #1;
    n_cmp++; if (memAddr_out !== 32'h0) begin n_fail++; $display("FAIL f0_addr got=%h want=0", memAddr_out); end
    n_cmp++; if (memRE_out !== 1'b1) begin n_fail++; $display("FAIL f0_re got=%b want=1", memRE_out); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL first_early_valid edge=%0d got=%b want=0", i, instValid_out); end
    end
    n_cmp++; if (memRE_out !== 1'b0) begin n_fail++; $display("FAIL w3_re got=%b want=0", memRE_out); end
    step();
    n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b want=1", instValid_out); end
    n_cmp++; if (inst_out !== 32'h0010_0513) begin n_fail++; $display("FAIL first_inst got=%h want=00100513", inst_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL first_pc got=%h want=0", pc_out); end
    n_cmp++; if (memAddr_out !== 32'h4) begin n_fail++; $display("FAIL next_addr got=%h want=4", memAddr_out); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) step();
    stall_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, instValid_out); end
      n_cmp++; if (inst_out !== 32'h0010_0513) begin n_fail++; $display("FAIL stall_inst cyc=%0d got=%h want=00100513", i, inst_out); end
      n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL stall_pc cyc=%0d got=%h want=0", i, pc_out); end
    end
    n_cmp++; if (memRE_out !== 1'b0) begin n_fail++; $display("FAIL pend_re got=%b want=0", memRE_out); end
    stall_in = 1'b0;
    step();
    n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL unstall_valid got=%b want=1", instValid_out); end
    n_cmp++; if (inst_out !== 32'h0020_0593) begin n_fail++; $display("FAIL unstall_inst got=%h want=00200593", inst_out); end
    n_cmp++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL unstall_pc got=%h want=4", pc_out); end
    n_cmp++; if (memAddr_out !== 32'h8) begin n_fail++; $display("FAIL unstall_addr got=%h want=8", memAddr_out); end
  endtask

  task automatic test_continuous();
    logic [31:0] exp_inst [4];
    exp_inst[0] = 32'h0010_0513;
    exp_inst[1] = 32'h0020_0593;
    exp_inst[2] = 32'h0030_0613;
    exp_inst[3] = 32'h0040_0693;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i <= 4; i++) begin
        step();
        n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL cont_gap k=%0d i=%0d got=%b want=0", k, i, instValid_out); end
      end
      step();
      n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL cont_valid k=%0d got=%b want=1", k, instValid_out); end
      n_cmp++; if (inst_out !== exp_inst[k]) begin n_fail++; $display("FAIL cont_inst k=%0d got=%h want=%h", k, inst_out, exp_inst[k]); end
      n_cmp++; if (pc_out !== 32'(4 * k)) begin n_fail++; $display("FAIL cont_pc k=%0d got=%h want=%h", k, pc_out, 32'(4 * k)); end
    end
  endtask

  task automatic check_target_fetch(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL %s_partial i=%0d got=%b want=0", tag, i, instValid_out); end
    end
    step();
    n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%b want=1", tag, instValid_out); end
    n_cmp++; if (inst_out !== 32'h0640_0713) begin n_fail++; $display("FAIL %s_inst got=%h want=06400713", tag, inst_out); end
    n_cmp++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL %s_pc got=%h want=100", tag, pc_out); end
  endtask

  task automatic test_branch_f2();
    do_reset();
    step();
    step();
    branch_in     = 1'b1;
    branchAddr_in = 32'h100;
    step();
    branch_in = 1'b0;
    n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL br_valid got=%b want=0", instValid_out); end
    n_cmp++; if (memAddr_out !== 32'h100) begin n_fail++; $display("FAIL br_addr got=%h want=100", memAddr_out); end
    n_cmp++; if (memRE_out !== 1'b1) begin n_fail++; $display("FAIL br_re got=%b want=1", memRE_out); end
    check_target_fetch("br_f2");
  endtask

  task automatic test_branch_w3_stall();
    do_reset();
    repeat (5) step();
    stall_in = 1'b1;
    repeat (4) step();
    n_cmp++; if (memRE_out !== 1'b0) begin n_fail++; $display("FAIL brw3_pre_re got=%b want=0", memRE_out); end
    n_cmp++; if (instValid_out !== 1'b1) begin n_fail++; $display("FAIL brw3_pre_valid got=%b want=1", instValid_out); end
    branch_in     = 1'b1;
    branchAddr_in = 32'h100;
    step();
    branch_in = 1'b0;
    stall_in  = 1'b0;
    n_cmp++; if (instValid_out !== 1'b0) begin n_fail++; $display("FAIL brw3_valid got=%b want=0", instValid_out); end
    n_cmp++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL brw3_inst got=%h want=0", inst_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL brw3_pc got=%h want=0", pc_out); end
    n_cmp++; if (memAddr_out !== 32'h100) begin n_fail++; $display("FAIL brw3_addr got=%h want=100", memAddr_out); end
    check_target_fetch("br_w3");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFFC;
    exp_addr[1] = 32'hFFFF_FFFD;
    exp_addr[2] = 32'hFFFF_FFFE;
    exp_addr[3] = 32'hFFFF_FFFF;
    do_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_addr2 !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr i=%0d got=%h want=%h", i, mem_addr2, exp_addr[i]); end
      step();
    end
    step();
    n_cmp++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got=%b want=1", valid2); end
    n_cmp++; if (inst2 !== 32'h1234_5678) begin n_fail++; $display("FAIL wrap_inst got=%h want=12345678", inst2); end
    n_cmp++; if (pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h want=fffffffc", pc2); end
    n_cmp++; if (mem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%h want=0", mem_addr2); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_continuous();
    test_branch_f2();
    test_branch_w3_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
